hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall unit for the 5-stage MIPS core.
- Replaces per-stage T_new decoding with a per-register countdown scoreboard, loaded at D->E issue.
- Owns the multiply/divide busy counter internally; the MDU is started from here through md_start.
- Sits beside the D stage and drives the stall that freezes PC/FD and bubbles DE.

Parameters:
NREG, 32, number of architectural registers tracked
AW, 5, register address width (log2 NREG)
TW, 2, width of Tuse/Tnew fields
ZERO_REG, 1, when 1 register 0 is never marked pending
MULT_LAT, 5, cycles mult/multu/mthi/mtlo hold HI/LO busy
DIV_LAT, 10, cycles div/divu hold HI/LO busy
MDW, 4, md counter width (must hold max(MULT_LAT,DIV_LAT))
CNT_W, 16, stall statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
d_valid  in  1  D holds a real instruction
d_rs  in  AW  D source register rs
d_rt  in  AW  D source register rt
d_tuse_rs  in  TW  cycles until rs is consumed (all-ones = not used)
d_tuse_rt  in  TW  cycles until rt is consumed (all-ones = not used)
d_wr_en  in  1  D instruction writes the GPR file
d_wr_addr  in  AW  D destination register
d_tnew  in  TW  Tnew the instruction will have once in E (load 2, calc 1, lui/jal 0)
d_md  in  1  D is mult/div/mthi/mtlo
d_div  in  1  with d_md: operation is a divide
d_hilo_use  in  1  D is mfhi/mflo/mthi/mtlo/mult/div (needs HI/LO idle)
ext_stall  in  1  global freeze (memory wait), freezes all state
clr  in  1  synchronous clear of the GPR scoreboard
stall  out  1  freeze D and insert bubble into E
md_start  out  1  start pulse to the MDU
md_busy  out  1  HI/LO result pending
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- State: sb[0..NREG-1] (TW bits each), md_cnt (MDW bits), stall_cycles.
- Reset (reset=0, asynchronous): every sb entry = 0, md_cnt = 0, stall_cycles = 0. Outputs then: stall=0, md_start=0, md_busy=0.
- Hazards, combinational from current state:
  - rs_haz = d_tuse_rs!=all-ones && sb[d_rs] > d_tuse_rs; rt_haz is the same for rt.
  - md_haz = d_hilo_use && md_cnt!=0.
  - stall = d_valid && (rs_haz || rt_haz || md_haz). stall ignores ext_stall.
- issue = d_valid && !stall && !ext_stall.
- Each clock edge with ext_stall=1: no state changes, except clr, which still clears.
- Each clock edge with ext_stall=0:
  - Every nonzero sb entry decrements by 1 (saturates at 0). Decrement continues while stall=1, because the producer keeps advancing.
  - If issue && d_wr_en && !(ZERO_REG && d_wr_addr==0): sb[d_wr_addr] <= d_tnew. The newer write overrides that entry's decrement in the same cycle.
  - clr=1 forces all sb to 0 and takes priority over issue. md_cnt is unaffected by clr.
- MD counter:
  - md_start = issue && d_md (combinational, one cycle).
  - On md_start edge: md_cnt <= d_div ? DIV_LAT : MULT_LAT.
  - Otherwise, when !ext_stall and md_cnt!=0: md_cnt decrements.
  - md_busy = md_cnt!=0.
- stall_cycles increments on edges with stall=1 && ext_stall=0 and saturates at 2^CNT_W-1.
- Reset mid-operation clears md_cnt and the scoreboard immediately, with no edge required.

Test Plan:
- lw $5 issues (wr 5, tnew 2); next D is addu rs=5 tuse 1 -> stall=1 for exactly 1 cycle, then issue; stall_cycles=1.
- lw $5 then sw rt=5 tuse_rt 2 -> stall never asserts; sb[5] reads 2,1,0 on successive cycles.
- mult issues (MULT_LAT=5, md_start pulse 1 cycle); next D is mflo -> stall=1 for 5 cycles; md_busy high 5 cycles, then mflo issues. Repeat with div -> 10 cycles.
- Write to $0 with tnew 2, then consumer rs=0 tuse 0 -> no stall. Two back-to-back writes to $7 with tnew 2 then 0 -> sb[7]=0 after the second issue.
- sb[5]=2, consumer tuse 0, ext_stall held 3 cycles -> sb[5] stays 2, stall stays 1, stall_cycles unchanged. After release: 2 stalled cycles, then issue.
- Drop reset low 2 cycles into a div -> md_busy=0 and stall=0 at once with no clock edge. clr with pending sb entries -> all hazards cleared on the next edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard scoreboard for the 5-stage MIPS core.
// Detects RAW and HI/LO hazards for the D stage, starts the MDU and counts stall cycles.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int ZERO_REG = 1,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int MDW      = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [AW-1:0]    d_rs,
    input  logic [AW-1:0]    d_rt,
    input  logic [TW-1:0]    d_tuse_rs,
    input  logic [TW-1:0]    d_tuse_rt,
    input  logic             d_wr_en,
    input  logic [AW-1:0]    d_wr_addr,
    input  logic [TW-1:0]    d_tnew,
    input  logic             d_md,
    input  logic             d_div,
    input  logic             d_hilo_use,
    input  logic             ext_stall,
    input  logic             clr,
    output logic             stall,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [TW-1:0]    TUSE_NONE = '1;
    localparam logic [MDW-1:0]   MULT_LOAD = MDW'(MULT_LAT);
    localparam logic [MDW-1:0]   DIV_LOAD  = MDW'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [TW-1:0]  sb      [NREG];
    logic [TW-1:0]  sb_next [NREG];
    logic [MDW-1:0] md_cnt;
    logic           rs_haz;
    logic           rt_haz;
    logic           md_haz;
    logic           issue;
    logic           sb_write;

    // A source whose Tuse is all-ones is not read, so it can never hazard.
    always_comb begin
        rs_haz   = (d_tuse_rs != TUSE_NONE) && (sb[d_rs] > d_tuse_rs);
        rt_haz   = (d_tuse_rt != TUSE_NONE) && (sb[d_rt] > d_tuse_rt);
        md_busy  = (md_cnt != '0);
        md_haz   = d_hilo_use && md_busy;
        stall    = d_valid && (rs_haz || rt_haz || md_haz);
        issue    = d_valid && !stall && !ext_stall;
        md_start = issue && d_md;
        sb_write = issue && d_wr_en && !((ZERO_REG != 0) && (d_wr_addr == '0));
    end

    // Producers keep advancing while D is stalled, so decrement regardless of stall.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_next[i] = sb[i];
            if (clr) begin
                sb_next[i] = '0;
            end else if (!ext_stall) begin
                if (sb[i] != '0) begin
                    sb_next[i] = sb[i] - TW'(1);
                end
                if (sb_write && (d_wr_addr == AW'(i))) begin
                    sb_next[i] = d_tnew;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                sb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                sb[i] <= sb_next[i];
            end
        end
    end

    // md_start is only possible without ext_stall, so the load wins over the hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= d_div ? DIV_LOAD : MULT_LOAD;
        end else if (!ext_stall && md_busy) begin
            md_cnt <= md_cnt - MDW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && !ext_stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against a per-register
// countdown reference model; a narrow stall counter exercises saturation.
module tb_hazard_scoreboard;

    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int MDW      = 4;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int NOT_USED = (1 << TW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             d_valid;
    logic [AW-1:0]    d_rs;
    logic [AW-1:0]    d_rt;
    logic [TW-1:0]    d_tuse_rs;
    logic [TW-1:0]    d_tuse_rt;
    logic             d_wr_en;
    logic [AW-1:0]    d_wr_addr;
    logic [TW-1:0]    d_tnew;
    logic             d_md;
    logic             d_div;
    logic             d_hilo_use;
    logic             ext_stall;
    logic             clr;
    logic             stall;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: remaining cycles until each register's value is ready,
    // cycles the HI/LO unit stays busy, and the expected stall count.
    int sb_m [NREG];
    int md_m;
    int cyc_m;
    logic last_stall;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .TW(TW), .ZERO_REG(1),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .MDW(MDW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .d_md(d_md), .d_div(d_div), .d_hilo_use(d_hilo_use),
        .ext_stall(ext_stall), .clr(clr),
        .stall(stall), .md_start(md_start), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                                 input bit wr, input int waddr, input int tnew,
                                 input bit md, input bit dv, input bit hilo, input bit ext, input bit cl);
        d_valid    = valid;
        d_rs       = AW'(rs);
        d_tuse_rs  = TW'(tuse_rs);
        d_rt       = AW'(rt);
        d_tuse_rt  = TW'(tuse_rt);
        d_wr_en    = wr;
        d_wr_addr  = AW'(waddr);
        d_tnew     = TW'(tnew);
        d_md       = md;
        d_div      = dv;
        d_hilo_use = hilo;
        ext_stall  = ext;
        clr        = cl;
    endtask

    task automatic nop();
        applyStimulus(0, 0, NOT_USED, 0, NOT_USED, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) sb_m[i] = 0;
        md_m  = 0;
        cyc_m = 0;
    endtask

    function automatic bit model_stall();
        bit h;
        h = 0;
        if (int'(d_tuse_rs) != NOT_USED && sb_m[int'(d_rs)] > int'(d_tuse_rs)) h = 1;
        if (int'(d_tuse_rt) != NOT_USED && sb_m[int'(d_rt)] > int'(d_tuse_rt)) h = 1;
        if (d_hilo_use && md_m > 0) h = 1;
        return d_valid && h;
    endfunction

    // Compare outputs for the current inputs, then advance one clock and the model.
    task automatic checkOutput(input string tag);
        bit es;
        bit ei;
        #1;
        es = model_stall();
        ei = d_valid && !es && !ext_stall;
        checkValue({tag, ".stall"}, 32'(stall), 32'(es));
        checkValue({tag, ".md_start"}, 32'(md_start), 32'(ei && d_md));
        checkValue({tag, ".md_busy"}, 32'(md_busy), 32'(md_m != 0));
        checkValue({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(cyc_m));
        last_stall = stall;
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < NREG; i++) sb_m[i] = 0;
        end else if (!ext_stall) begin
            for (int i = 0; i < NREG; i++) if (sb_m[i] > 0) sb_m[i]--;
            if (ei && d_wr_en && d_wr_addr != 0) sb_m[int'(d_wr_addr)] = int'(d_tnew);
        end
        if (ei && d_md) md_m = d_div ? DIV_LAT : MULT_LAT;
        else if (!ext_stall && md_m > 0) md_m--;
        if (es && !ext_stall && cyc_m < CNT_MAX) cyc_m++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        nop();
        for (int i = 0; i < n; i++) checkOutput("idle");
    endtask

    initial begin
        int n;
        reset = 1'b0;
        nop();
        model_reset();
        #2;
        checkValue("reset.stall", 32'(stall), 0);
        checkValue("reset.md_busy", 32'(md_busy), 0);
        checkValue("reset.md_start", 32'(md_start), 0);
        checkValue("reset.stall_cycles", 32'(stall_cycles), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        $display("[TB] load-use: lw $5 then addu rs=5");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 5, 2, 0, 0, 0, 0, 0);
        checkOutput("lw5");
        applyStimulus(1, 5, 1, 6, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        checkOutput("addu_stall");
        checkValue("addu.first_stalled", 32'(last_stall), 1);
        checkOutput("addu_issue");
        checkValue("addu.then_issued", 32'(last_stall), 0);
        checkValue("addu.stall_cycles", 32'(stall_cycles), 1);
        idle(3);

        $display("[TB] lw $5 then sw rt=5 tuse 2");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 5, 2, 0, 0, 0, 0, 0);
        checkOutput("lw5b");
        applyStimulus(1, 4, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("sw");
            checkValue("sw.no_stall", 32'(last_stall), 0);
        end
        idle(2);

        $display("[TB] mult / div then mflo");
        for (int op = 0; op < 2; op++) begin
            applyStimulus(1, 3, 0, 4, 0, 0, 0, 0, 1, op[0], 1, 0, 0);
            checkOutput("md_issue");
            applyStimulus(1, 0, NOT_USED, 0, NOT_USED, 1, 8, 1, 0, 0, 1, 0, 0);
            n = 0;
            for (int k = 0; k < 30; k++) begin
                checkOutput("mflo");
                if (last_stall) n++;
                else break;
            end
            checkValue(op == 0 ? "mult.stall_len" : "div.stall_len", n, op == 0 ? MULT_LAT : DIV_LAT);
            idle(3);
        end

        $display("[TB] register 0 and back-to-back writes");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 0, 2, 0, 0, 0, 0, 0);
        checkOutput("wr0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("use0");
        checkValue("r0.no_stall", 32'(last_stall), 0);
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 7, 2, 0, 0, 0, 0, 0);
        checkOutput("wr7a");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("wr7b");
        applyStimulus(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("use7");
        checkValue("r7.no_stall", 32'(last_stall), 0);
        idle(2);

        $display("[TB] ext_stall freezes the scoreboard");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 5, 2, 0, 0, 0, 0, 0);
        checkOutput("lw5c");
        n = int'(stall_cycles);
        applyStimulus(1, 5, 0, 6, NOT_USED, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("ext_hold");
            checkValue("ext.stall_held", 32'(last_stall), 1);
        end
        checkValue("ext.count_frozen", 32'(stall_cycles), 32'(n));
        d_valid = 1; ext_stall = 0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            checkOutput("ext_release");
            if (last_stall) n++;
            else break;
        end
        checkValue("ext.stall_after_release", n, 2);
        idle(2);

        $display("[TB] async reset during a divide");
        applyStimulus(1, 3, 0, 4, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        checkOutput("div_issue");
        applyStimulus(1, 0, NOT_USED, 0, NOT_USED, 1, 8, 1, 0, 0, 1, 0, 0);
        checkOutput("mflo_pre");
        checkOutput("mflo_pre");
        reset = 1'b0;
        #1;
        checkValue("async_reset.md_busy", 32'(md_busy), 0);
        checkValue("async_reset.stall", 32'(stall), 0);
        checkValue("async_reset.stall_cycles", 32'(stall_cycles), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        $display("[TB] clr drops pending entries");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 5, 2, 0, 0, 0, 0, 0);
        checkOutput("lw5d");
        applyStimulus(1, 1, NOT_USED, 2, NOT_USED, 1, 6, 2, 0, 0, 0, 0, 0);
        checkOutput("lw6");
        applyStimulus(1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("clr");
        checkValue("clr.stalled_before", 32'(last_stall), 1);
        clr = 0;
        checkOutput("after_clr");
        checkValue("clr.no_stall_after", 32'(last_stall), 0);
        idle(1);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 600; it++) begin
            bit md;
            md = ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 9) < 8,
                          $urandom_range(0, 7), $urandom_range(0, 3),
                          $urandom_range(0, 7), $urandom_range(0, 3),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2),
                          md, $urandom_range(0, 1) == 1,
                          md || ($urandom_range(0, 6) == 0),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
